adder_xbit_serial_sync: RTL and testbench

Parameterised DATA_WIDTH-bit ripple-carry (serial-carry) adder with a registered output stage. The carry propagates combinationally through a chain of 1-bit full adders, and the sum plus carry-out are captured on the clock edge. It is a reusable arithmetic leaf in the common adder library, used wherever a registered A+B+Cin is needed.

---
 rtl/adder_xbit_serial_sync_pkg.sv | 6 +
 rtl/adder_1bit_full.sv | 17 +
 rtl/adder_xbit_serial_sync.sv | 52 +++++
 tb/tb_adder_xbit_serial_sync.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/adder_xbit_serial_sync_pkg.sv
// Shared constants for the serial-carry adder slice.
package adder_xbit_serial_sync_pkg;

   localparam int unsigned DEFAULT_DATA_WIDTH = 4;

endpackage

// File: rtl/adder_1bit_full.sv
// One-bit full adder: the single stage of the ripple-carry chain.
module adder_1bit_full (
   input  logic i_num_a,
   input  logic i_num_b,
   input  logic i_cry,
   output logic o_res,
   output logic o_cry
);

   logic half_sum;

   assign half_sum = i_num_a ^ i_num_b;
   assign o_res    = half_sum ^ i_cry;
   // Generate on a&b, propagate the incoming carry when exactly one operand bit is set.
   assign o_cry    = (i_num_a & i_num_b) | (i_cry & half_sum);

endmodule

// File: rtl/adder_xbit_serial_sync.sv
// DATA_WIDTH-bit ripple-carry adder computing A+B+Cin, with the sum and carry-out
// captured in an output register one cycle after a valid input.
module adder_xbit_serial_sync
   import adder_xbit_serial_sync_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_vld,
   input  logic [DATA_WIDTH-1:0] i_num_a,
   input  logic [DATA_WIDTH-1:0] i_num_b,
   input  logic                  i_cry,
   output logic                  o_vld,
   output logic [DATA_WIDTH-1:0] o_res,
   output logic                  o_cry
);

   // carry[k] is the carry into bit k; carry[DATA_WIDTH] is the carry-out.
   logic [DATA_WIDTH:0]   carry;
   logic [DATA_WIDTH-1:0] sum;

   assign carry[0] = i_cry;

   for (genvar k = 0; k < DATA_WIDTH; k++) begin : g_stage
      adder_1bit_full u_fa (
         .i_num_a (i_num_a[k]),
         .i_num_b (i_num_b[k]),
         .i_cry   (carry[k]),
         .o_res   (sum[k]),
         .o_cry   (carry[k+1])
      );
   end

   // NOTE: async reset clears the whole output stage so an in-flight result is dropped;
   // the result flops only load on i_vld and otherwise hold, which is intended here.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_vld <= 1'b0;
         o_res <= '0;
         o_cry <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
         o_vld <= i_vld;
         if (i_vld) begin
            o_res <= sum;
            o_cry <= carry[DATA_WIDTH];
         end
      end
   end

endmodule

// File: tb/tb_adder_xbit_serial_sync.sv
// Scoreboard bench for adder_xbit_serial_sync at DATA_WIDTH = 4.
module tb_adder_xbit_serial_sync;

   localparam int W    = 4;
   localparam int HALF = 5;

   typedef struct {
      logic [W-1:0] res;
      logic         cry;
      string        tag;
   } exp_t;

   logic         i_clk;
   logic         i_rst;
   logic         i_vld;
   logic [W-1:0] i_num_a;
   logic [W-1:0] i_num_b;
   logic         i_cry;
   logic         o_vld;
   logic [W-1:0] o_res;
   logic         o_cry;

   exp_t         exp_q[$];
   logic [W-1:0] last_res;
   logic         last_cry;
   int           n_checks;
   int           n_fail;

   adder_xbit_serial_sync #(.DATA_WIDTH(W)) dut (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_vld   (i_vld),
      .i_num_a (i_num_a),
      .i_num_b (i_num_b),
      .i_cry   (i_cry),
      .o_vld   (o_vld),
      .o_res   (o_res),
      .o_cry   (o_cry)
   );

   initial i_clk = 1'b0;
   always #HALF i_clk = ~i_clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
      end
   endtask

   // Compare whatever the DUT registered at the last rising edge.
   task automatic compare_outputs();
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check({e.tag, "/vld"}, 32'(o_vld), 32'd1);
         check({e.tag, "/res"}, 32'(o_res), 32'(e.res));
         check({e.tag, "/cry"}, 32'(o_cry), 32'(e.cry));
         last_res = e.res;
         last_cry = e.cry;
      end else begin
         check("idle/vld", 32'(o_vld), 32'd0);
         check("hold/res", 32'(o_res), 32'(last_res));
         check("hold/cry", 32'(o_cry), 32'(last_cry));
      end
   endtask

   // One cycle: check the previous result, then drive new inputs and push the expectation.
   task automatic step(input string tag, input logic v, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic c,
                       input logic [W-1:0] er, input logic ec);
      exp_t e;
      @(negedge i_clk);
      compare_outputs();
      i_vld   = v;
      i_num_a = a;
      i_num_b = b;
      i_cry   = c;
      if (v) begin
         e.res = er;
         e.cry = ec;
         e.tag = tag;
         exp_q.push_back(e);
      end
   endtask

   // Asynchronous reset pulse placed mid-cycle; anything in flight is discarded.
   task automatic mid_reset(input string tag);
      #(HALF - 2);
      i_rst = 1'b1;
      i_vld = 1'b0;
      #1;
      check({tag, "/vld"}, 32'(o_vld), 32'd0);
      check({tag, "/res"}, 32'(o_res), 32'd0);
      check({tag, "/cry"}, 32'(o_cry), 32'd0);
      exp_q.delete();
      last_res = '0;
      last_cry = 1'b0;
      @(posedge i_clk);
      @(negedge i_clk);
      i_rst = 1'b0;
   endtask

   task automatic directed_stream();
      step("z+z+0",     1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0);
      step("f+f+0",     1'b1, 4'b1111, 4'b1111, 1'b0, 4'b1110, 1'b1);
      step("c+9+0",     1'b1, 4'b1100, 4'b1001, 1'b0, 4'b0101, 1'b1);
      step("7+6+0",     1'b1, 4'b0111, 4'b0110, 1'b0, 4'b1101, 1'b0);
      step("5+5+1",     1'b1, 4'b0101, 4'b0101, 1'b1, 4'b1011, 1'b0);
      step("e+9+1",     1'b1, 4'b1110, 4'b1001, 1'b1, 4'b1000, 1'b1);
      step("2+6+1",     1'b1, 4'b0010, 4'b0110, 1'b1, 4'b1001, 1'b0);
      step("6+c+1",     1'b1, 4'b0110, 4'b1100, 1'b1, 4'b0011, 1'b1);
      step("ripple",    1'b1, 4'b1111, 4'b0000, 1'b1, 4'b0000, 1'b1);
      step("wrap_ff1",  1'b1, 4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1);
   endtask

   initial begin
      logic [W-1:0] ra, rb;
      logic         rc;
      logic [W:0]   full;

      n_checks = 0;
      n_fail   = 0;
      last_res = '0;
      last_cry = 1'b0;
      i_rst    = 1'b1;
      i_vld    = 1'b0;
      i_num_a  = '0;
      i_num_b  = '0;
      i_cry    = 1'b0;

      repeat (2) @(posedge i_clk);
      @(negedge i_clk);
      i_rst = 1'b0;

      // Load a nonzero result, then check the asynchronous clear without a clock edge.
      step("preload", 1'b1, 4'b1111, 4'b1111, 1'b0, 4'b1110, 1'b1);
      step("preload_idle", 1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0);
      mid_reset("async_rst");

      // Directed vectors, then the hold check after 6+c+1.
      step("z+z+0", 1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0);
      step("f+f+0", 1'b1, 4'b1111, 4'b1111, 1'b0, 4'b1110, 1'b1);
      step("6+c+1", 1'b1, 4'b0110, 4'b1100, 1'b1, 4'b0011, 1'b1);
      step("hold_drop", 1'b0, 4'b1010, 4'b0101, 1'b0, 4'b0000, 1'b0);
      step("hold_more", 1'b0, 4'b1111, 4'b1111, 1'b1, 4'b0000, 1'b0);

      // Back-to-back stream; every cycle expects o_vld high with the prior input's result.
      directed_stream();

      // Reset between two valid inputs: the second one is in flight and must vanish.
      step("pre_rst", 1'b1, 4'b0011, 4'b0100, 1'b0, 4'b0111, 1'b0);
      step("inflight", 1'b1, 4'b1000, 4'b1000, 1'b0, 4'b0000, 1'b1);
      mid_reset("stream_rst");
      step("post_rst_idle", 1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0);
      step("post_rst", 1'b1, 4'b1001, 4'b0110, 1'b1, 4'b0000, 1'b1);

      // Random back-to-back traffic with occasional bubbles.
      for (int i = 0; i < 40; i++) begin
         ra   = W'($urandom);
         rb   = W'($urandom);
         rc   = 1'($urandom);
         full = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
         step("rand", ($urandom_range(0, 3) != 0), ra, rb, rc, full[W-1:0], full[W]);
      end

      step("drain", 1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0);
      step("drain_idle", 1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
